// File: rtl/sparse_gf2_matvec_pingpong_if.sv
// Stream bundle for sparse_gf2_matvec_pingpong: one input word stream and one result word stream.
// Optional last/error sideband is present when SPARSE_GF2_MATVEC_LAST_EN is defined.
interface sparse_gf2_matvec_pingpong_if #(
  parameter int WIDTH = 96
);
  // Valid/ready: a word moves on a rising clock edge where valid and ready are both high;
  // the source holds data (and last) stable while valid is high and ready is low.
  logic [WIDTH-1:0] i_input_data;
  logic             i_input_valid;
  logic             o_input_ready;
  logic [WIDTH-1:0] o_output_data;
  logic             o_output_valid;
  logic             i_output_ready;
`ifdef SPARSE_GF2_MATVEC_LAST_EN
  logic             i_input_last;
  logic             o_output_last;
  logic             o_frame_error;

  modport slave (
    input  i_input_data, i_input_valid, i_input_last, i_output_ready,
    output o_input_ready, o_output_data, o_output_valid, o_output_last, o_frame_error
  );
  modport master (
    output i_input_data, i_input_valid, i_input_last, i_output_ready,
    input  o_input_ready, o_output_data, o_output_valid, o_output_last, o_frame_error
  );
`else
  modport slave (
    input  i_input_data, i_input_valid, i_output_ready,
    output o_input_ready, o_output_data, o_output_valid
  );
  modport master (
    output i_input_data, i_input_valid, i_output_ready,
    input  o_input_ready, o_output_data, o_output_valid
  );
`endif
endinterface

// File: rtl/sparse_gf2_matvec_pingpong.sv
// Sparse GF(2) matrix-vector multiply with ping-pong result banks for the LDPC encoder.
// Optional frame-last checking is enabled by defining SPARSE_GF2_MATVEC_LAST_EN.
module sparse_gf2_matvec_pingpong #(
  parameter int WIDTH = 96,
  parameter int INPUT_LENGTH = 11,
  parameter int OUTPUT_LENGTH = 1,
  parameter logic [OUTPUT_LENGTH*INPUT_LENGTH-1:0] ROW_MASKS =
    {{(OUTPUT_LENGTH*INPUT_LENGTH-1){1'b0}}, 1'b1}
) (
  input logic i_clock,
  input logic i_reset,
  sparse_gf2_matvec_pingpong_if.slave bus
);
  localparam int IN_CW  = (INPUT_LENGTH > 1) ? $clog2(INPUT_LENGTH) : 1;
  localparam int OUT_CW = (OUTPUT_LENGTH > 1) ? $clog2(OUTPUT_LENGTH) : 1;
  localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(INPUT_LENGTH - 1);
  localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUTPUT_LENGTH - 1);

  logic [OUTPUT_LENGTH*WIDTH-1:0] bank [2];
  logic [1:0]                     full;
  logic                           fill_sel;
  logic                           read_sel;
  logic [IN_CW-1:0]               in_cnt;
  logic [OUT_CW-1:0]              out_cnt;
  logic                           in_fire;
  logic                           out_fire;
  logic                           in_end;
  logic                           out_end;
  logic                           frame_abort;
  logic [WIDTH-1:0]               rd_word;
  logic [INPUT_LENGTH-1:0]        row_bits;
  logic [OUTPUT_LENGTH-1:0]       col_hit;

  // Ready and valid come only from registered flags; reset forces both low.
  assign bus.o_input_ready  = !i_reset && !full[fill_sel];
  assign bus.o_output_valid = !i_reset && full[read_sel];
  assign rd_word            = bank[read_sel][int'(out_cnt)*WIDTH +: WIDTH];
  assign bus.o_output_data  = bus.o_output_valid ? rd_word : '0;

  assign in_fire  = bus.i_input_valid && bus.o_input_ready;
  assign out_fire = bus.o_output_valid && bus.i_output_ready;
  assign in_end   = (in_cnt == IN_LAST);
  assign out_end  = (out_cnt == OUT_LAST);

`ifdef SPARSE_GF2_MATVEC_LAST_EN
  logic frame_error_q;

  assign frame_abort       = bus.i_input_last && !in_end;
  assign bus.o_output_last = bus.o_output_valid && out_end;
  assign bus.o_frame_error = frame_error_q;

  // Sticky: any disagreement between i_input_last and the word count.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      frame_error_q <= 1'b0;
    end else if (in_fire && (bus.i_input_last != in_end)) begin
      frame_error_q <= 1'b1;
    end
  end
`else
  assign frame_abort = 1'b0;
`endif

  // Which result rows take the current input column.
  always_comb begin
    row_bits = '0;
    col_hit  = '0;
    for (int r = 0; r < OUTPUT_LENGTH; r++) begin
      row_bits   = ROW_MASKS[r*INPUT_LENGTH +: INPUT_LENGTH];
      col_hit[r] = |(row_bits & (INPUT_LENGTH'(1) << in_cnt));
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bank[0]  <= '0;
      bank[1]  <= '0;
      full     <= '0;
      fill_sel <= 1'b0;
      read_sel <= 1'b0;
      in_cnt   <= '0;
      out_cnt  <= '0;
    end else begin
      if (in_fire) begin
        // Column 0 seeds every row, so stale bank contents never leak into a new frame.
        for (int r = 0; r < OUTPUT_LENGTH; r++) begin
          if (col_hit[r]) begin
            bank[fill_sel][r*WIDTH +: WIDTH] <= (in_cnt == '0) ? bus.i_input_data
              : (bank[fill_sel][r*WIDTH +: WIDTH] ^ bus.i_input_data);
          end else if (in_cnt == '0) begin
            bank[fill_sel][r*WIDTH +: WIDTH] <= '0;
          end
        end
        if (in_end) begin
          in_cnt         <= '0;
          full[fill_sel] <= 1'b1;
          fill_sel       <= !fill_sel;
        end else if (frame_abort) begin
          in_cnt <= '0;
        end else begin
          in_cnt <= in_cnt + IN_CW'(1);
        end
      end
      // A filling bank is never full and a read bank always is, so both flag updates can land together.
      if (out_fire) begin
        if (out_end) begin
          out_cnt        <= '0;
          full[read_sel] <= 1'b0;
          read_sel       <= !read_sel;
        end else begin
          out_cnt <= out_cnt + OUT_CW'(1);
        end
      end
    end
  end
endmodule

// File: doc/sparse_gf2_matvec_pingpong.md
Name: sparse_gf2_matvec_pingpong

Overview:
Parametrised sparse GF(2) matrix-vector multiply for the LDPC encoder datapath. Generalises the fixed 11-in/1-out "multiply by E" stage to any INPUT_LENGTH × OUTPUT_LENGTH sparse binary matrix, given as a row-mask parameter. Each output word is the XOR of the selected input words, accumulated on the fly into one of two ping-pong banks. The full bank streams out while the other bank fills.

Parameters:
WIDTH, 96, bits per data word (one vector element).
INPUT_LENGTH, 11, input words per frame; legal range ≥2.
OUTPUT_LENGTH, 1, output words per frame; legal range ≥1.
ROW_MASKS, {{(OUTPUT_LENGTH*INPUT_LENGTH-1){1'b0}},1'b1}, packed matrix. Row r occupies bits [r*INPUT_LENGTH +: INPUT_LENGTH]. Bit c set means input word c contributes to output word r.

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_input_data  in  WIDTH  input vector word
i_input_valid  in  1  input word valid
o_input_ready  out  1  block can accept an input word
o_output_data  out  WIDTH  result word; 0 when not valid
o_output_valid  out  1  result word valid
i_output_ready  in  1  downstream accepts result word

Behaviour:
Decided interface rule: reset i_reset, synchronous, active-high; clock i_clock.

Storage:
- Two banks (0 and 1), each holding OUTPUT_LENGTH words of WIDTH.
- Per-bank full flags: full[1:0].
- fill_sel and read_sel, 1 bit each.
- in_cnt over 0..INPUT_LENGTH-1; out_cnt over 0..OUTPUT_LENGTH-1. Each counter is at least 1 bit wide.

Reset:
- All bank words, full flags, selects and counters go to 0.
- o_output_valid=0, o_output_data=0, o_input_ready=0 during reset.
- A partial frame in progress when reset asserts is discarded.

Input side:
- o_input_ready = !full[fill_sel] (registered state only). There is no combinational path from i_output_ready to o_input_ready.
- On an input accept (valid & ready) with in_cnt=c, update every row r in bank[fill_sel]:
  - c==0: word[r] <= ROW_MASKS[r][0] ? data : 0.
  - c>0 and mask bit set: word[r] <= word[r] ^ data.
  - c>0 and mask bit clear: word[r] unchanged.
- A row with an all-zero mask yields 0.
- On accept with c==INPUT_LENGTH-1: in_cnt <= 0, full[fill_sel] <= 1, fill_sel toggles. Otherwise in_cnt increments.
- i_input_valid while not ready is ignored; no state change.

Output side:
- o_output_valid = full[read_sel].
- o_output_data = bank[read_sel].word[out_cnt] when valid, else 0.
- Data and valid are held stable until accepted.
- On an output accept with out_cnt==OUTPUT_LENGTH-1: out_cnt <= 0, full[read_sel] <= 0, read_sel toggles. Otherwise out_cnt increments.

Timing:
- Latency: first result word is valid the cycle after the last input word is accepted.
- With i_output_ready held high and OUTPUT_LENGTH ≤ INPUT_LENGTH, input runs at full rate with no bubbles.
- When the fill bank is still full, input ready rises the cycle after that bank's final output accept (one-cycle bubble).
- Simultaneous set/clear in one cycle always targets different banks. Both updates apply.
- Both banks full: o_input_ready=0 until the read bank drains.

Optional Feature:
Macro SPARSE_GF2_MATVEC_LAST_EN.

Defined:
- Adds i_input_last (in, 1), o_output_last (out, 1) and o_frame_error (out, 1, sticky, cleared only by reset).
- o_output_last = o_output_valid & (out_cnt==OUTPUT_LENGTH-1).
- An accepted word with i_input_last=1 and in_cnt≠INPUT_LENGTH-1:
  - sets o_frame_error;
  - aborts the frame: in_cnt <= 0, bank not marked full, no output produced.
- An accepted word with in_cnt==INPUT_LENGTH-1 and i_input_last=0:
  - sets o_frame_error;
  - the frame still completes normally.

Undefined: none of these ports exist, and frame length is counter-only.

Test Plan:
1. Defaults; input words 1..11, output ready high → single output 0x1, valid exactly one cycle after word 11 accepted; o_input_ready never drops.
2. INPUT_LENGTH=4, OUTPUT_LENGTH=2, row0=4'b0101, row1=4'b1110; inputs A=0x3,B=0x5,C=0x9,D=0x10 → outputs 0xA (A^C) then 0x1C (B^C^D).
3. Defaults, i_output_ready low, three back-to-back frames (first words 0x7, 0x8, 0x9) → o_input_ready falls after frame 2. Raise ready → 0x7, 0x8 emitted in order, then frame 3 accepted → 0x9.
4. Case 2 config, deassert i_output_ready for 3 cycles mid-frame on word 0 → o_output_data held at 0xA, valid high; no word lost or duplicated.
5. Assert i_reset after 5 words of a frame → outputs 0 and not valid. Next full frame 1..11 (defaults) → output 0x1 only.
6. LAST_EN, defaults, i_input_last on word 6 → o_frame_error=1, no output. Next correct frame → output produced, o_output_last=1 with it.
